// File: rtl/axis_skid_slice.sv
// ---------------------------------------------------------------------------
// axis_skid_slice
//
// AXI-Stream register slice with a two-entry skid buffer. Sustains one beat
// per clock and absorbs one extra beat when downstream stalls, so s_ready can
// be a plain flop with no combinational path from m_ready. Also counts
// delivered packets and can optionally throttle s_ready for flow-control
// testing.
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_s_data    upstream beat data            [DATA_WIDTH]
//   i_s_valid   upstream beat valid
//   o_s_ready   slice can accept (flop)
//   i_s_last    upstream end-of-packet
//   o_m_data    downstream beat data (flop)   [DATA_WIDTH]
//   o_m_valid   downstream beat valid
//   i_m_ready   downstream accept
//   o_m_last    downstream end-of-packet
//   o_level     beats held: 0, 1 or 2
//   o_pkt_cnt   beats delivered with last=1, wrapping   [CNT_WIDTH]
//
// Build option
//   AXIS_SLICE_THROTTLE_EN  when defined, a cycle counter allows s_ready for
//                           READY_ON cycles then forces it low for READY_OFF
//                           cycles, repeating from reset release.
//
// States
//   state    | meaning
//   ---------+------------------------------------------
//   ST_EMPTY | nothing held, m_valid low
//   ST_ONE   | output register full, skid register empty
//   ST_TWO   | output and skid full, s_ready low
// ---------------------------------------------------------------------------
module axis_skid_slice #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int READY_ON   = 3,
  parameter int READY_OFF  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic                  i_s_last,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic [1:0]            o_level,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt
);

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1 || READY_ON < 1 || READY_OFF < 0) begin : g_cfg_check
    $error("axis_skid_slice: illegal parameter combination");
  end

  // Encoding equals the number of beats held, so o_level is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_s_ready;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_last;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic                  w_s_acc;
  logic                  w_m_acc;
  logic                  w_m_valid;
  logic                  w_out_load;
  logic                  w_out_from_skid;
  logic                  w_skid_load;
  logic                  w_thr_open;

  assign w_m_valid = (r_state != ST_EMPTY);
  assign w_s_acc   = i_s_valid && r_s_ready;
  assign w_m_acc   = w_m_valid && i_m_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_s_acc) w_state_nxt = ST_ONE;
      end
      ST_ONE: begin
        if (w_m_acc && !w_s_acc)      w_state_nxt = ST_EMPTY;
        else if (w_s_acc && !w_m_acc) w_state_nxt = ST_TWO;
      end
      ST_TWO: begin
        if (w_m_acc) w_state_nxt = ST_ONE;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    w_out_load      = 1'b0;
    w_out_from_skid = 1'b0;
    w_skid_load     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_out_load = w_s_acc;
      end
      ST_ONE: begin
        // Output drains while a new beat arrives: new beat goes straight to
        // the output register. Output stalled: new beat parks in the skid.
        w_out_load  = w_s_acc && w_m_acc;
        w_skid_load = w_s_acc && !w_m_acc;
      end
      ST_TWO: begin
        w_out_load      = w_m_acc;
        w_out_from_skid = 1'b1;
      end
      default: begin
        w_out_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
    end else begin
      if (w_out_load) begin
        r_m_data <= w_out_from_skid ? r_skid_data : i_s_data;
        r_m_last <= w_out_from_skid ? r_skid_last : i_s_last;
      end
      if (w_skid_load) begin
        r_skid_data <= i_s_data;
        r_skid_last <= i_s_last;
      end
    end
  end

  // s_ready is registered from the next state, so it falls the cycle after
  // the skid fills and never looks at m_ready or s_valid combinationally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt != ST_TWO) && w_thr_open;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_cnt <= '0;
    end else if (w_m_acc && r_m_last) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Ready throttle
  // -------------------------------------------------------------------------
`ifdef AXIS_SLICE_THROTTLE_EN
  localparam int THR_PERIOD = READY_ON + READY_OFF;
  localparam int THR_W      = (THR_PERIOD > 1) ? $clog2(THR_PERIOD) : 1;

  // Phase of the cycle whose s_ready is being computed at this edge; phase 0
  // is the first cycle after reset release.
  logic [THR_W-1:0] r_thr_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_thr_cnt <= '0;
    end else if (r_thr_cnt == THR_W'(THR_PERIOD - 1)) begin
      r_thr_cnt <= '0;
    end else begin
      r_thr_cnt <= r_thr_cnt + THR_W'(1);
    end
  end

  // With no off-phase the compare constant would not fit the counter, so the
  // gate is simply held open.
  if (READY_OFF == 0) begin : g_thr_always
    assign w_thr_open = 1'b1;
  end else begin : g_thr_gate
    assign w_thr_open = (r_thr_cnt < THR_W'(READY_ON));
  end
`else
  assign w_thr_open = 1'b1;
`endif

  assign o_s_ready = r_s_ready;
  assign o_m_data  = r_m_data;
  assign o_m_last  = r_m_last;
  assign o_m_valid = w_m_valid;
  assign o_level   = r_state;
  assign o_pkt_cnt = r_pkt_cnt;

endmodule
